// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: shared address map constants and decode helper
// Holds the IO base, cycle-counter address and RAM-limit constants that
// the memory and load/store queue logic also key off.
package bus_responder_pkg;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] CNT_ADDR = 18'h30004;
  localparam int RAM_LIMIT_BITS = 17;
  typedef enum logic [1:0] {REGION_RAM, REGION_IO, REGION_NONE} region_t;
  function automatic region_t decode(input logic [17:0] a);
    return a[17:16] == 2'b11 ? REGION_IO : !a[17] ? REGION_RAM : REGION_NONE;
  endfunction
endpackage

// File: rtl/bus_responder_fifo.sv
// byte_fifo: byte-wide FIFO, pop on non-empty, push accepted when a slot is free
// Ports: clk, rst_n (async active-low), push/din, pop, dout (head), count,
// full, empty. A push while full is accepted only if a pop frees the slot
// on the same edge.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/bus_responder.sv
// bus_responder: CPU bus slave with byte RAM, UART TX/RX ports, cycle counter and halt
// Ports: clk_in, rst_in (async active-low), rdy_in (global pause),
// mem_a/mem_dout/mem_wr (CPU request), mem_din (registered read data),
// io_buffer_full (TX back-pressure), tx_data/tx_valid/tx_ready (UART TX),
// rx_data/rx_valid/rx_ready (UART RX, rx_ready a one-cycle pop), halt.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int ADDR_BITS = RAM_LIMIT_BITS,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic [7:0] ram [2**ADDR_BITS];
  logic [31:0] counter, snapshot;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, push, pop, rd, wr;
  logic [7:0] push_data, rd_data, io_data;
  logic [17:0] a;
  region_t region;
  logic unused_addr;
  assign unused_addr = ^mem_a[31:18];
  assign a = mem_a[17:0];
  assign region = decode(a);
  assign rd = rdy_in && !mem_wr;
  assign wr = rdy_in && mem_wr && !halt;
  // The halt write pushes a 0x00 marker, bypassing the zero filter of the data port.
  assign push = wr && ((a == IO_BASE && mem_dout != 8'h00) || a == CNT_ADDR);
  assign push_data = a == CNT_ADDR ? 8'h00 : mem_dout;
  assign pop = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;
  // One entry of slack: the CPU sees full one cycle late and may still push once.
  assign io_buffer_full = fifo_full || fifo_count >= CW'(TX_DEPTH - 1);
  // 0x30004 returns the live counter byte; 0x30005..7 return the snapshot it took.
  assign io_data = a == IO_BASE ? (rx_valid ? rx_data : 8'h00) :
                   a[17:2] != CNT_ADDR[17:2] ? 8'h00 :
                   a[1:0] == 2'd0 ? counter[7:0] : 8'(snapshot >> {a[1:0], 3'b000});
  assign rd_data = region == REGION_RAM ? ram[mem_a[ADDR_BITS-1:0]] :
                   region == REGION_IO ? io_data : 8'h00;
  byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk_in),
    .rst_n(rst_in),
    .push(push),
    .din(push_data),
    .pop(pop),
    .dout(tx_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      mem_din <= 8'h00;
      rx_ready <= 1'b0;
      counter <= '0;
      snapshot <= '0;
      halt <= 1'b0;
    end else begin
      rx_ready <= rd && a == IO_BASE && rx_valid;
      if (rdy_in) counter <= counter + 32'd1;
      if (rd) mem_din <= rd_data;
      if (rd && a == CNT_ADDR) snapshot <= counter;
      if (wr && a == CNT_ADDR) halt <= 1'b1;
    end
  always_ff @(posedge clk_in)
    if (wr && region == REGION_RAM) ram[mem_a[ADDR_BITS-1:0]] <= mem_dout;
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 17, meaning RAM byte-address width (2^17 = 128 KiB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, meaning UART TX FIFO entries (power of two, at least 4).
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rdy_in, input, 1, global pause; no bus access is served while low.
REQ-006 SHALL have port mem_a, input, 32, byte address from the CPU; only [17:0] is decoded.
REQ-007 SHALL have port mem_dout, input, 8, write data from the CPU.
REQ-008 SHALL have port mem_wr, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port mem_din, output, 8, read data to the CPU.
REQ-010 SHALL have port io_buffer_full, output, 1, UART TX back-pressure to the CPU.
REQ-011 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), the UART TX valid/ready stream.
REQ-012 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1), the UART RX stream; rx_ready is a one-cycle pop pulse.
REQ-013 SHALL have port halt, output, 1, a sticky program-stop flag.

Function
REQ-014 SHALL decode each cycle with rdy_in=1: mem_a[17:16]==2'b11 is IO; mem_a[17]==0 is RAM (byte index mem_a[ADDR_BITS-1:0]); otherwise unmapped.
REQ-015 SHALL serve RAM reads with 1-cycle latency: data is registered into mem_din on the edge after the address is presented.
REQ-016 SHALL commit RAM writes on the same edge they are presented (no wait); a read of the same address on the next cycle returns the new byte.
REQ-017 SHALL handle unmapped accesses as: read returns 0x00 next cycle, write is dropped.
REQ-018 SHALL handle a write to 0x30000 as: a non-zero byte is pushed into the TX FIFO; 0x00 is ignored; a push while the FIFO is full is dropped.
REQ-019 SHALL handle a read of 0x30000 as: mem_din = rx_data if rx_valid, else 0x00; rx_ready pulses for 1 cycle only when rx_valid was 1.
REQ-020 SHALL keep a 32-bit cycle counter that increments every cycle with rdy_in=1 and wraps from 0xFFFFFFFF to 0.
REQ-021 SHALL, on a read of 0x30004, return counter[7:0] and snapshot the full counter; reads of 0x30005/6/7 return snapshot bytes 1/2/3.
REQ-022 SHALL, on a write to 0x30004, set halt and push 0x00 into the TX FIFO (bypassing REQ-018's zero filter); once halt is set, all later writes are ignored and reads still complete.
REQ-023 SHALL drive io_buffer_full = 1 while the FIFO count is at least TX_DEPTH-1, giving one entry of slack for the CPU's one-cycle reaction.
REQ-024 SHALL drive tx_valid = FIFO not empty and tx_data = FIFO head; pop on tx_valid and tx_ready; the FIFO drains regardless of rdy_in.
REQ-025 SHALL leave the count unchanged on a simultaneous push and pop, including when the FIFO is full (the pop frees the slot).
REQ-026 SHALL, while rdy_in=0, hold mem_din, not commit writes, not pulse rx_ready, and hold the counter.

Reset
REQ-027 SHALL, on rst_in low (asynchronous), force mem_din=0, FIFO empty, tx_valid=0, io_buffer_full=0, rx_ready=0, counter=0, snapshot=0 and halt=0; RAM contents are not reset.
REQ-028 SHALL discard any access in flight when reset asserts; after rst_in rises, the first served access is on the first edge with rdy_in=1.

Structure
REQ-029 SHALL take the IO base (0x30000), counter address (0x30004) and RAM-limit constants from the shared defines header used by memory and LSqueue.
REQ-030 SHALL implement the TX FIFO as a sub-module byte_fifo (parameter DEPTH; push/pop/count/full/empty); the RAM array is inline.

Verification
REQ-031 SHALL cover: write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 exactly one edge later.
REQ-032 SHALL cover: writes of 'H' (0x48) and 0x00 to 0x30000 with tx_ready=1 -> only 0x48 appears on tx_data.
REQ-033 SHALL cover: tx_ready=0, 7 non-zero writes to 0x30000 -> io_buffer_full=1 after the 7th; an 8th is accepted, a 9th is dropped; raise tx_ready -> 8 bytes drain in order.
REQ-034 SHALL cover: counter at 0x000000FF, read 0x30004 then 0x30005 -> bytes 0xFF then 0x00, taken from the snapshot even though the counter has moved on.
REQ-035 SHALL cover: write to 0x30004 -> halt=1, tx_data=0x00 emitted; a later write to 0x00020 leaves RAM unchanged.
REQ-036 SHALL cover: rdy_in=0 during a write to 0x00030 and pulse rst_in low mid-stream -> no RAM change, all outputs at reset values immediately, without waiting for a clock edge.
